// File: rtl/morse_decoder.sv
// Morse symbol-vector decoder: scans five 2-bit slots, validates,
// looks up ITU A-Z/0-9 and holds the ASCII result under valid/ready.
module morse_decoder #(
  parameter logic [7:0] ERR_CHAR   = 8'h3F,
  parameter logic [7:0] SPACE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] code_in,
  input  logic       code_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE, SCAN, LOOKUP, HOLD
  } state_t;

  state_t      state, state_n;
  logic [9:0]  sreg, sreg_n;
  logic [2:0]  cnt, cnt_n;
  logic [2:0]  len, len_n;
  logic [4:0]  pat, pat_n;
  logic        bad, bad_n;
  logic        started, started_n;
  logic [7:0]  char_n;
  logic        err_n;
  logic [1:0]  sym;
  logic [8:0]  hit;

  // {found, ascii}; first symbol sits at bit len-1, long=1
  function automatic logic [8:0] lut(input logic [7:0] key);
    logic [8:0] r;
    r = {1'b0, ERR_CHAR};
    case (key)
      {3'd2, 5'b00001}: r = {1'b1, 8'h41};
      {3'd4, 5'b01000}: r = {1'b1, 8'h42};
      {3'd4, 5'b01010}: r = {1'b1, 8'h43};
      {3'd3, 5'b00100}: r = {1'b1, 8'h44};
      {3'd1, 5'b00000}: r = {1'b1, 8'h45};
      {3'd4, 5'b00010}: r = {1'b1, 8'h46};
      {3'd3, 5'b00110}: r = {1'b1, 8'h47};
      {3'd4, 5'b00000}: r = {1'b1, 8'h48};
      {3'd2, 5'b00000}: r = {1'b1, 8'h49};
      {3'd4, 5'b00111}: r = {1'b1, 8'h4A};
      {3'd3, 5'b00101}: r = {1'b1, 8'h4B};
      {3'd4, 5'b00100}: r = {1'b1, 8'h4C};
      {3'd2, 5'b00011}: r = {1'b1, 8'h4D};
      {3'd2, 5'b00010}: r = {1'b1, 8'h4E};
      {3'd3, 5'b00111}: r = {1'b1, 8'h4F};
      {3'd4, 5'b00110}: r = {1'b1, 8'h50};
      {3'd4, 5'b01101}: r = {1'b1, 8'h51};
      {3'd3, 5'b00010}: r = {1'b1, 8'h52};
      {3'd3, 5'b00000}: r = {1'b1, 8'h53};
      {3'd1, 5'b00001}: r = {1'b1, 8'h54};
      {3'd3, 5'b00001}: r = {1'b1, 8'h55};
      {3'd4, 5'b00001}: r = {1'b1, 8'h56};
      {3'd3, 5'b00011}: r = {1'b1, 8'h57};
      {3'd4, 5'b01001}: r = {1'b1, 8'h58};
      {3'd4, 5'b01011}: r = {1'b1, 8'h59};
      {3'd4, 5'b01100}: r = {1'b1, 8'h5A};
      {3'd5, 5'b11111}: r = {1'b1, 8'h30};
      {3'd5, 5'b01111}: r = {1'b1, 8'h31};
      {3'd5, 5'b00111}: r = {1'b1, 8'h32};
      {3'd5, 5'b00011}: r = {1'b1, 8'h33};
      {3'd5, 5'b00001}: r = {1'b1, 8'h34};
      {3'd5, 5'b00000}: r = {1'b1, 8'h35};
      {3'd5, 5'b10000}: r = {1'b1, 8'h36};
      {3'd5, 5'b11000}: r = {1'b1, 8'h37};
      {3'd5, 5'b11100}: r = {1'b1, 8'h38};
      {3'd5, 5'b11110}: r = {1'b1, 8'h39};
      default:          r = {1'b0, ERR_CHAR};
    endcase
    return r;
  endfunction

  assign sym       = sreg[9:8];
  assign hit       = lut({len, pat});
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    len_n     = len;
    pat_n     = pat;
    bad_n     = bad;
    started_n = started;
    char_n    = out_char;
    err_n     = out_err;
    unique case (state)
      IDLE: begin
        if (code_valid) begin
          sreg_n    = code_in;
          cnt_n     = 3'd0;
          len_n     = 3'd0;
          pat_n     = 5'd0;
          bad_n     = 1'b0;
          started_n = 1'b0;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        sreg_n = {sreg[7:0], 2'b00};
        cnt_n  = cnt + 3'd1;
        unique case (sym)
          2'b10, 2'b11: begin
            started_n = 1'b1;
            pat_n     = {pat[3:0], sym[0]};
            len_n     = len + 3'd1;
          end
          2'b00: if (started) bad_n = 1'b1;
          2'b01: bad_n = 1'b1;
        endcase
        if (cnt == 3'd4) state_n = LOOKUP;
      end
      LOOKUP: begin
        unique case (1'b1)
          bad: begin
            char_n = ERR_CHAR;
            err_n  = 1'b1;
          end
          (!bad && len == 3'd0): begin
            char_n = SPACE_CHAR;
            err_n  = 1'b0;
          end
          default: begin
            char_n = hit[7:0];
            err_n  = ~hit[8];
          end
        endcase
        state_n = HOLD;
      end
      HOLD: if (out_ready) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= 10'd0;
      cnt      <= 3'd0;
      len      <= 3'd0;
      pat      <= 5'd0;
      bad      <= 1'b0;
      started  <= 1'b0;
      out_char <= 8'h00;
      out_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      cnt      <= cnt_n;
      len      <= len_n;
      pat      <= pat_n;
      bad      <= bad_n;
      started  <= started_n;
      out_char <= char_n;
      out_err  <= err_n;
      overrun  <= code_valid && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: decodes, errors, backpressure,
// overrun and mid-scan reset against hand-computed ASCII values.
module tb_morse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] code_in;
  logic       code_valid;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  morse_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_valid(code_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] v);
    code_in    = v;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic decode(input string tag, input logic [9:0] v,
                        input logic [7:0] c, input logic e);
    int n;
    out_ready = 1'b1;
    pulse(v);
    wait_valid(n);
    chk({tag, "_lat"}, n, 6);
    chk({tag, "_char"}, out_char, c);
    chk({tag, "_err"}, out_err, e);
    tick();
    chk({tag, "_vld0"}, out_valid, 1'b0);
    chk({tag, "_busy0"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int extra;
    rst_n      = 1'b0;
    code_in    = '0;
    code_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_char", out_char, 8'h00);
    chk("rst_err", out_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    tick();

    decode("A", 10'b00_00_00_10_11, 8'h41, 1'b0);
    decode("D0", 10'b11_11_11_11_11, 8'h30, 1'b0);
    decode("D1", 10'b10_11_11_11_11, 8'h31, 1'b0);
    decode("H", 10'b00_10_10_10_10, 8'h48, 1'b0);
    decode("SP", 10'b00_00_00_00_00, 8'h20, 1'b0);
    decode("GAP", 10'b00_10_00_11_10, 8'h3F, 1'b1);
    decode("ILL", 10'b00_00_00_01_10, 8'h3F, 1'b1);
    decode("UNK", 10'b00_10_10_11_11, 8'h3F, 1'b1);
    decode("T", 10'b00_00_00_00_11, 8'h54, 1'b0);
    decode("D9", 10'b11_11_11_11_10, 8'h39, 1'b0);

    // backpressure
    out_ready = 1'b0;
    pulse(10'b00_10_10_10_10);
    wait_valid(n);
    chk("bp_lat", n, 6);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_vld", out_valid, 1'b1);
      chk("bp_char", out_char, 8'h48);
      chk("bp_err", out_err, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_vld0", out_valid, 1'b0);
    chk("bp_busy0", busy, 1'b0);

    // overrun: second strobe lands mid-scan
    pulse(10'b00_00_00_10_11);
    chk("ov_none", overrun, 1'b0);
    tick();
    pulse(10'b00_00_00_00_10);
    chk("ov_pulse", overrun, 1'b1);
    tick();
    chk("ov_clear", overrun, 1'b0);
    wait_valid(n);
    chk("ov_lat", n, 3);
    chk("ov_char", out_char, 8'h41);
    tick();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("ov_extra", extra, 0);
    decode("OVE", 10'b00_00_00_00_10, 8'h45, 1'b0);

    // reset during the third scan cycle
    pulse(10'b11_11_11_11_11);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mr_busy", busy, 1'b0);
    chk("mr_vld", out_valid, 1'b0);
    chk("mr_char", out_char, 8'h00);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) extra++;
      tick();
    end
    chk("mr_extra", extra, 0);
    decode("MRE", 10'b00_00_00_00_10, 8'h45, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Downstream stage of the Morse keyer/accumulator. Consumes the finished 10-bit symbol vector on the finish strobe and translates it to an uppercase ASCII character.
- Multi-cycle FSM: scans the five 2-bit symbol slots, validates the pattern, looks it up in the ITU Morse table (A-Z, 0-9), then holds the result under a valid/ready handshake for the display/UART stage.

Parameters:
ERR_CHAR, 8'h3F, character emitted for malformed or unknown patterns ('?')
SPACE_CHAR, 8'h20, character emitted for an all-empty vector

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
code_in  input  10  symbol vector; slots s4=[9:8] (oldest) .. s0=[1:0] (newest); 2'b10 short, 2'b11 long, 2'b00 empty, 2'b01 illegal
code_valid  input  1  one-cycle strobe, code_in sampled when busy=0
out_ready  input  1  consumer accepts out_char when high with out_valid
busy  output  1  high in any state other than IDLE
out_valid  output  1  out_char/out_err valid
out_char  output  8  decoded ASCII
out_err  output  1  high with out_valid when ERR_CHAR emitted
overrun  output  1  one-cycle pulse: code_valid seen while busy (vector dropped)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, out_valid=0, out_char=8'h00, out_err=0, overrun=0; internal len=0, pat=0, bad=0, started=0. Reset overrides everything, including mid-SCAN or HOLD; the pending result is discarded.
- States: IDLE -> SCAN -> LOOKUP -> HOLD -> IDLE.
- IDLE: code_valid=1 latches code_in into shift reg, clears len/pat/bad/started, slot counter=0, goes to SCAN.
- SCAN: exactly 5 cycles, one slot per cycle, s4 first.
  - 00 before first non-empty: skipped.
  - 10 / 11: started=1, pat={pat[3:0], sym[0]}, len+1.
  - 00 after started: bad=1.
  - 01 at any position: bad=1.
  - After slot s0, go to LOOKUP.
- LOOKUP (1 cycle):
  - len=0 and bad=0: out_char=SPACE_CHAR, out_err=0.
  - bad=1: out_char=ERR_CHAR, out_err=1.
  - Otherwise (len,pat) is matched against the ITU table (first symbol = MSB of the len-bit pattern, long=1). Hit gives the ASCII letter/digit with out_err=0; miss gives ERR_CHAR with out_err=1.
  - Go to HOLD.
- HOLD: out_valid=1. out_char/out_err stable until out_valid&out_ready at a clk edge, then out_valid=0 and state returns to IDLE in that same edge.
- Latency: capture edge E0 -> out_valid=1 after edge E6. A consumer that is always ready sees out_valid for one cycle.
- The next code_valid is accepted in the first cycle busy=0 (cycle after the handshake).
- code_valid while busy (SCAN/LOOKUP/HOLD): input ignored, overrun=1 for the following cycle only.
- Widths: len 3 bits (0..5), pat 5 bits. No arithmetic overflow is possible because len saturates by construction (5 slots).

Test Plan:
- Letter A: code_in=10'b00_00_00_10_11, out_ready=1 -> out_valid high 6 edges after capture, out_char=8'h41, out_err=0, busy=0 next cycle.
- Digit and 5-symbol path: code_in=10'b11_11_11_11_11 -> out_char=8'h30. code_in=10'b10_11_11_11_11 -> 8'h31. code_in=10'b00_10_10_10_10 -> 8'h48 ('H').
- Empty/space and errors:
  - all-zero -> 8'h20, out_err=0.
  - inner gap 10'b00_10_00_11_10 -> 8'h3F, out_err=1.
  - illegal 10'b00_00_00_01_10 -> 8'h3F, out_err=1.
  - unknown 10'b00_10_10_11_11 ("..--") -> 8'h3F, out_err=1.
- Backpressure: out_ready=0 for 4 cycles after out_valid -> out_char/out_err held, busy=1. Raise out_ready -> single handshake, out_valid=0 next cycle.
- Overrun: second code_valid 2 cycles after first -> overrun pulse 1 cycle, only the first character produced. A third code_valid after busy falls is decoded normally.
- Reset mid-operation: rst_n=0 during SCAN cycle 3 -> next cycle busy=0, out_valid=0, out_char=8'h00. A subsequent 'E' (10'b00_00_00_00_10) decodes to 8'h45.
